axi4_lite_master_arbiter: RTL and testbench

//  Shares one AXI4-Lite master port between two requesters: port D (MEM stage load/store) and port I (instruction fetch, read-only).

---
 rtl/axi4_lite_master_arbiter_pkg.sv | 27 ++
 rtl/axi4_lite_master_arbiter_rr_arbiter2.sv | 42 ++++
 rtl/axi4_lite_master_arbiter.sv | 176 +++++++++++++++++
 tb/tb_axi4_lite_master_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_master_arbiter_pkg.sv
// Shared definitions for the two-port AXI4-Lite master arbiter.
//   axi_state_t   : channel FSM states (IDLE, WR = AW+W, WB = B, RA = AR, RD = R)
//   port_id_t     : requester ids (PORT_D = MEM-stage load/store, PORT_I = fetch)
//   AXI_RESP_OKAY : the only response code treated as success
//   resp_is_err() : maps an AXI response code to the requester error flag
package axi4_lite_master_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_WB   = 3'd2,
      ST_RA   = 3'd3,
      ST_RD   = 3'd4
   } axi_state_t;

   typedef enum logic {
      PORT_D = 1'b0,
      PORT_I = 1'b1
   } port_id_t;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi4_lite_master_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
//   clk, rst     : clock, asynchronous active-high reset
//   req_d, req_i : eligible requests this cycle
//   update       : the grant is being taken this cycle; advance the pointer
//   grant_valid  : at least one request present
//   grant_id     : winning port (combinational)
// After reset the pointer holds PORT_I, so D wins the first tie.
module axi4_lite_master_arbiter_rr_arbiter2
   import axi4_lite_master_arbiter_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     req_d,
   input  logic     req_i,
   input  logic     update,
   output logic     grant_valid,
   output port_id_t grant_id
);

   port_id_t last_grant;

   always_comb begin
      grant_valid = req_d | req_i;
      if (req_d && req_i) begin
         // tie: favour whoever did not win last time
         grant_id = (last_grant == PORT_D) ? PORT_I : PORT_D;
      end else if (req_d) begin
         grant_id = PORT_D;
      end else begin
         grant_id = PORT_I;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= PORT_I;
      end else if (update && grant_valid) begin
         last_grant <= grant_id;
      end
   end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between a load/store requester (D) and an
// instruction-fetch requester (I, read only). One transaction at a time; the
// payload is registered at grant, and the completion pulse, error flag and
// read data are returned to the requester that owns the transaction.
//   clk, rst                    : clock, asynchronous active-high reset
//   d_req/d_we/d_addr/d_wdata/d_wstrb : D request (level, held until d_done)
//   d_done/d_rdata/d_err/d_busy : D completion pulse, held read data, error, stall
//   i_req/i_addr                : I read request (level, held until i_done)
//   i_done/i_rdata/i_err/i_busy : I completion pulse, held read data, error, stall
//   m_*                         : AXI4-Lite master channels AW, W, B, AR, R
module axi4_lite_master_arbiter
   import axi4_lite_master_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   output logic                    d_done,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    d_err,
   output logic                    d_busy,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_done,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   output logic                    i_err,
   output logic                    i_busy,
   output logic [ADDR_WIDTH-1:0]   m_awaddr,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready,
   output logic [ADDR_WIDTH-1:0]   m_araddr,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rvalid,
   output logic                    m_rready
);

   axi_state_t state;
   port_id_t   owner;
   logic       elig_d;
   logic       elig_i;
   logic       grant_valid;
   port_id_t   grant_id;
   logic       grant_fire;
   logic       aw_complete;
   logic       w_complete;

   // A requester whose done pulse is high this cycle is still holding its
   // level request; it must not be re-granted off that stale level.
   assign elig_d     = d_req & ~d_done;
   assign elig_i     = i_req & ~i_done;
   assign grant_fire = (state == ST_IDLE) & grant_valid;

   assign d_busy = d_req & ~d_done;
   assign i_busy = i_req & ~i_done;

   // In WR a channel is finished once its valid has dropped or it is
   // handshaking now; valids only drop on a handshake in this state.
   assign aw_complete = ~m_awvalid | m_awready;
   assign w_complete  = ~m_wvalid  | m_wready;

   axi4_lite_master_arbiter_rr_arbiter2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_d       (elig_d),
      .req_i       (elig_i),
      .update      (grant_fire),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= PORT_D;
         m_awaddr  <= '0;
         m_awvalid <= 1'b0;
         m_wdata   <= '0;
         m_wstrb   <= '0;
         m_wvalid  <= 1'b0;
         m_bready  <= 1'b0;
         m_araddr  <= '0;
         m_arvalid <= 1'b0;
         m_rready  <= 1'b0;
         d_done    <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= '0;
         i_done    <= 1'b0;
         i_err     <= 1'b0;
         i_rdata   <= '0;
      end else begin
         d_done <= 1'b0;
         d_err  <= 1'b0;
         i_done <= 1'b0;
         i_err  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  owner <= grant_id;
                  if (grant_id == PORT_D && d_we) begin
                     m_awaddr  <= d_addr;
                     m_wdata   <= d_wdata;
                     m_wstrb   <= d_wstrb;
                     m_awvalid <= 1'b1;
                     m_wvalid  <= 1'b1;
                     state     <= ST_WR;
                  end else begin
                     m_araddr  <= (grant_id == PORT_D) ? d_addr : i_addr;
                     m_arvalid <= 1'b1;
                     state     <= ST_RA;
                  end
               end
            end
            ST_WR: begin
               if (m_awvalid && m_awready) begin
                  m_awvalid <= 1'b0;
               end
               if (m_wvalid && m_wready) begin
                  m_wvalid <= 1'b0;
               end
               if (aw_complete && w_complete) begin
                  m_bready <= 1'b1;
                  state    <= ST_WB;
               end
            end
            ST_WB: begin
               if (m_bvalid) begin
                  m_bready <= 1'b0;
                  d_done   <= 1'b1;
                  d_err    <= resp_is_err(m_bresp);
                  state    <= ST_IDLE;
               end
            end
            ST_RA: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= ST_RD;
               end
            end
            ST_RD: begin
               if (m_rvalid) begin
                  m_rready <= 1'b0;
                  state    <= ST_IDLE;
                  if (owner == PORT_D) begin
                     d_done  <= 1'b1;
                     d_err   <= resp_is_err(m_rresp);
                     d_rdata <= m_rdata;
                  end else begin
                     i_done  <= 1'b1;
                     i_err   <= resp_is_err(m_rresp);
                     i_rdata <= m_rdata;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
`timescale 1ns/1ps
module tb_axi4_lite_master_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [3:0]    d_wstrb = '0;
   logic          d_done, d_err, d_busy;
   logic [DW-1:0] d_rdata;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_done, i_err, i_busy;
   logic [DW-1:0] i_rdata;
   logic [AW-1:0] m_awaddr, m_araddr;
   logic          m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
   logic [DW-1:0] m_wdata;
   logic [3:0]    m_wstrb;
   logic          m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
   logic          m_bvalid = 1'b0, m_rvalid = 1'b0;
   logic [1:0]    m_bresp = 2'b00, m_rresp = 2'b00;
   logic [DW-1:0] m_rdata = '0;

   always #5 clk = ~clk;

   axi4_lite_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err), .d_busy(d_busy),
      .i_req(i_req), .i_addr(i_addr),
      .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err), .i_busy(i_busy),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int i_done_cnt = 0;
   int ord_q[$];
   int dcyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (i_done) i_done_cnt <= i_done_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- slave: configurable wait states, own memory ----------------
   int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
   logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
   logic [31:0] smem [64];
   int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic got_aw, got_w, got_ar, b_hs_p, r_hs_p;
   logic [AW-1:0] s_awaddr, s_araddr;
   logic [DW-1:0] s_wdata;
   logic [3:0]    s_wstrb;
   int aw_hs_cyc = -1, w_hs_cyc = -1;

   initial begin
      for (int k = 0; k < 64; k++) smem[k] = 32'hC0DE_0000 | 32'(k);
      forever begin
         @(negedge clk);
         if (rst) begin
            m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            got_aw = 0; got_w = 0; got_ar = 0; b_hs_p = 0; r_hs_p = 0;
         end else begin
            if (b_hs_p) m_bvalid = 0;
            if (r_hs_p) m_rvalid = 0;
            b_hs_p = 0; r_hs_p = 0;
            if (m_awvalid) begin
               m_awready = (aw_cnt >= aw_wait); aw_cnt++;
               if (m_awready) begin got_aw = 1; s_awaddr = m_awaddr; aw_hs_cyc = cyc; aw_cnt = 0; end
            end else begin m_awready = 0; aw_cnt = 0; end
            if (m_wvalid) begin
               m_wready = (w_cnt >= w_wait); w_cnt++;
               if (m_wready) begin got_w = 1; s_wdata = m_wdata; s_wstrb = m_wstrb; w_hs_cyc = cyc; w_cnt = 0; end
            end else begin m_wready = 0; w_cnt = 0; end
            // got_* were set this negedge only for a handshake at the coming edge,
            // so B may start no earlier than the following cycle
            if (got_aw && got_w && !m_bvalid && !m_awready && !m_wready) begin
               if (b_cnt >= b_wait) begin
                  for (int b = 0; b < 4; b++)
                     if (s_wstrb[b]) smem[s_awaddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
                  m_bvalid = 1; m_bresp = bresp_cfg; got_aw = 0; got_w = 0; b_cnt = 0;
               end else b_cnt++;
            end
            if (m_bvalid && m_bready) b_hs_p = 1;
            if (m_arvalid) begin
               m_arready = (ar_cnt >= ar_wait); ar_cnt++;
               if (m_arready) begin got_ar = 1; s_araddr = m_araddr; ar_cnt = 0; end
            end else begin m_arready = 0; ar_cnt = 0; end
            if (got_ar && !m_rvalid && !m_arready) begin
               if (r_cnt >= r_wait) begin
                  m_rvalid = 1; m_rdata = smem[s_araddr[7:2]]; m_rresp = rresp_cfg; got_ar = 0; r_cnt = 0;
               end else r_cnt++;
            end
            if (m_rvalid && m_rready) r_hs_p = 1;
         end
      end
   end

   // ---------------- transaction-level model + per-cycle compare ----------------
   logic [31:0] mmem [64];
   logic mdl_busy, mdl_owner, mdl_we, mdl_last;
   int   mdl_done_at;
   logic [AW-1:0] mdl_addr;
   logic [DW-1:0] mdl_wdata, mdl_d_rd, mdl_i_rd;
   logic [3:0]    mdl_strb;
   logic e_dd, e_id, e_de, e_ie, ed, ei, take_i;
   logic [31:0] mask;

   initial begin
      for (int k = 0; k < 64; k++) mmem[k] = 32'hC0DE_0000 + 32'(k);
      mdl_busy = 0; mdl_last = 1; mdl_d_rd = '0; mdl_i_rd = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mdl_busy = 0; mdl_last = 1; mdl_d_rd = '0; mdl_i_rd = '0;
            chk("rst_outputs", {d_done, d_err, i_done, i_err, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, '0);
            chk("rst_rdata", {d_rdata, i_rdata}, '0);
         end else begin
            e_dd = 0; e_id = 0; e_de = 0; e_ie = 0;
            if (mdl_busy && mdl_done_at == cyc) begin
               mdl_busy = 0;
               if (mdl_we) begin
                  mask = {{8{mdl_strb[3]}}, {8{mdl_strb[2]}}, {8{mdl_strb[1]}}, {8{mdl_strb[0]}}};
                  mmem[mdl_addr[7:2]] = (mmem[mdl_addr[7:2]] & ~mask) | (mdl_wdata & mask);
                  e_dd = 1; e_de = (bresp_cfg != 2'b00);
               end else if (!mdl_owner) begin
                  e_dd = 1; e_de = (rresp_cfg != 2'b00); mdl_d_rd = mmem[mdl_addr[7:2]];
               end else begin
                  e_id = 1; e_ie = (rresp_cfg != 2'b00); mdl_i_rd = mmem[mdl_addr[7:2]];
               end
            end
            chk("d_done", d_done, e_dd);
            chk("i_done", i_done, e_id);
            chk("d_err", d_err, e_de);
            chk("i_err", i_err, e_ie);
            chk("d_rdata", d_rdata, mdl_d_rd);
            chk("i_rdata", i_rdata, mdl_i_rd);
            chk("d_busy", d_busy, d_req && !e_dd);
            chk("i_busy", i_busy, i_req && !e_id);
            if (!mdl_busy) begin
               chk("idle_channels", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, '0);
               ed = d_req && !e_dd;
               ei = i_req && !e_id;
               if (ed || ei) begin
                  take_i = ei && (!ed || !mdl_last);
                  mdl_busy = 1; mdl_owner = take_i; mdl_last = take_i;
                  mdl_we = !take_i && d_we;
                  mdl_addr = take_i ? i_addr : d_addr;
                  mdl_wdata = d_wdata; mdl_strb = d_wstrb;
                  mdl_done_at = cyc + 3 + (mdl_we ? ((aw_wait > w_wait ? aw_wait : w_wait) + b_wait)
                                                  : (ar_wait + r_wait));
               end
            end
         end
      end
   end

   // ---------------- requester drivers ----------------
   task automatic d_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output int lat, output logic err, output logic [31:0] rd);
      int start;
      logic seen;
      start = cyc; seen = 0; lat = -1; err = 1'bx; rd = 'x;
      d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; d_wstrb = strb;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (d_done) begin
            seen = 1; lat = cyc - start; err = d_err; rd = d_rdata;
            ord_q.push_back(0); dcyc_q.push_back(cyc);
         end
      end
      chk("d_op_completed", seen, 1'b1);
      @(posedge clk); #1;
      d_req = 0; d_addr = 32'hDEAD_BEEF; d_wdata = 32'hFFFF_FFFF; d_wstrb = 4'hF;
   endtask

   task automatic i_op(input logic [31:0] addr, output int lat, output logic err, output logic [31:0] rd);
      int start;
      logic seen;
      start = cyc; seen = 0; lat = -1; err = 1'bx; rd = 'x;
      i_req = 1; i_addr = addr;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(negedge clk);
         if (i_done) begin
            seen = 1; lat = cyc - start; err = i_err; rd = i_rdata;
            ord_q.push_back(1); dcyc_q.push_back(cyc);
         end
      end
      chk("i_op_completed", seen, 1'b1);
      @(posedge clk); #1;
      i_req = 0; i_addr = 32'hBAD0_0000;
   endtask

   task automatic do_reset();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int lat, lat2, t0, cnt0;
      logic err, err2;
      logic [31:0] rd, rd2;
      logic seen;

      #1 rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, '0);
      chk("reset_done", {d_done, i_done, d_err, i_err}, '0);
      chk("reset_rdata", {d_rdata, i_rdata}, '0);
      rst = 0;
      @(posedge clk); #1;

      // 1: single write, zero-wait slave
      t0 = cyc;
      d_op(1, 32'h10, 32'hA5A5_A5A5, 4'b1111, lat, err, rd);
      chk("t1_latency", lat, 3);
      chk("t1_err", err, 0);
      chk("t1_aw_cycle", aw_hs_cyc, t0 + 1);
      chk("t1_w_cycle", w_hs_cyc, t0 + 1);
      chk("t1_slave_mem", smem[4], 32'hA5A5_A5A5);

      // 2: read back, then a partial-strobe write merged onto seed 0xC0DE0005
      cnt0 = i_done_cnt;
      d_op(0, 32'h10, 32'h0, 4'h0, lat, err, rd);
      chk("t2_rdata", rd, 32'hA5A5_A5A5);
      chk("t2_latency", lat, 3);
      chk("t2_no_i_done", i_done_cnt - cnt0, 0);
      d_op(1, 32'h14, 32'h1122_3344, 4'b0101, lat, err, rd);
      d_op(0, 32'h14, 32'h0, 4'h0, lat, err, rd);
      chk("t2_strobe_merge", rd, 32'hC022_0044);

      // 3: simultaneous held requests after reset -> D, I, D, I
      do_reset();
      ord_q.delete(); dcyc_q.delete();
      t0 = cyc;
      fork
         begin
            d_op(0, 32'h10, 32'h0, 4'h0, lat, err, rd);
            d_op(0, 32'h14, 32'h0, 4'h0, lat, err, rd);
         end
         begin
            i_op(32'h20, lat2, err2, rd2);
            i_op(32'h24, lat2, err2, rd2);
         end
      join
      chk("t3_count", ord_q.size(), 4);
      for (int k = 0; k < ord_q.size() && k < 4; k++) begin
         chk("t3_order", ord_q[k], k % 2);
         chk("t3_done_cycle", dcyc_q[k], t0 + 3 * (k + 1));
      end

      // 4: awready two cycles late, wready immediate
      aw_wait = 2;
      t0 = cyc;
      fork
         d_op(1, 32'h18, 32'h0BAD_F00D, 4'hF, lat, err, rd);
         begin
            repeat (3) @(negedge clk);
            chk("t4_wvalid_dropped", m_wvalid, 0);
            chk("t4_awvalid_held", m_awvalid, 1);
            chk("t4_no_bready_early", m_bready, 0);
            @(negedge clk);
            chk("t4_no_bready_aw_hs", m_bready, 0);
            chk("t4_awvalid_at_hs", m_awvalid, 1);
            @(negedge clk);
            chk("t4_bready", m_bready, 1);
            chk("t4_awvalid_gone", m_awvalid, 0);
         end
      join
      aw_wait = 0;
      chk("t4_latency", lat, 5);
      chk("t4_w_cycle", w_hs_cyc, t0 + 1);
      chk("t4_aw_cycle", aw_hs_cyc, t0 + 3);
      d_op(0, 32'h18, 32'h0, 4'h0, lat, err, rd);
      chk("t4_readback", rd, 32'h0BAD_F00D);

      // 5: error responses
      bresp_cfg = 2'b10;
      d_op(1, 32'h20, 32'h1234_5678, 4'hF, lat, err, rd);
      bresp_cfg = 2'b00;
      chk("t5_d_err", err, 1);
      chk("t5_d_latency", lat, 3);
      rresp_cfg = 2'b11;
      i_op(32'h40, lat, err, rd);
      rresp_cfg = 2'b00;
      chk("t5_i_err", err, 1);
      chk("t5_i_rdata", rd, 32'hC0DE_0010);
      i_op(32'h44, lat, err, rd);
      chk("t5_i_err_clear", err, 0);
      chk("t5_i_rdata2", rd, 32'hC0DE_0011);

      // 7: request dropped after one cycle still completes
      t0 = cyc; seen = 0; lat = -1;
      i_req = 1; i_addr = 32'h48;
      @(posedge clk); #1;
      i_req = 0; i_addr = 32'hBAD0_0000;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (i_done) begin seen = 1; lat = cyc - t0; rd = i_rdata; end
      end
      chk("t7_done_seen", seen, 1);
      chk("t7_latency", lat, 3);
      chk("t7_rdata", rd, 32'hC0DE_0012);
      @(posedge clk); #1;

      // 6: reset while waiting in RD
      r_wait = 20;
      t0 = cyc;
      i_req = 1; i_addr = 32'h44;
      repeat (3) @(negedge clk);
      chk("t6_in_rd_rready", m_rready, 1);
      chk("t6_in_rd_arvalid", m_arvalid, 0);
      @(posedge clk); #1;
      cnt0 = i_done_cnt;
      rst = 1;
      #1;
      chk("t6_async_clear", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, i_done}, '0);
      i_req = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      r_wait = 0;
      repeat (25) @(posedge clk);
      #1;
      chk("t6_no_done_after", i_done_cnt - cnt0, 0);
      chk("t6_i_rdata_reset", i_rdata, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
